// File: rtl/autoseller_multi_if.sv
// Purchase handshake and result bundle for autoseller_multi.
// revenue_o exists only when AUTOSELLER_REVENUE_EN is defined.
interface autoseller_multi_if #(
   parameter int MONEY_W = 6,
   parameter int TYPE_W  = 2
);
   logic               enable_i;
   logic [MONEY_W-1:0] money_i;
   logic [TYPE_W-1:0]  drinktype_i;
   logic               restock_i;
   logic               ready_o;
   logic               enable_o;
   logic [MONEY_W-1:0] change_o;
   logic [TYPE_W-1:0]  drink_o;
   logic               vend_o;
   logic [1:0]         status_o;
`ifdef AUTOSELLER_REVENUE_EN
   logic [15:0]        revenue_o;

   modport master (
      output enable_i, money_i, drinktype_i, restock_i,
      input  ready_o, enable_o, change_o, drink_o, vend_o, status_o, revenue_o
   );
   modport slave (
      input  enable_i, money_i, drinktype_i, restock_i,
      output ready_o, enable_o, change_o, drink_o, vend_o, status_o, revenue_o
   );
`else
   modport master (
      output enable_i, money_i, drinktype_i, restock_i,
      input  ready_o, enable_o, change_o, drink_o, vend_o, status_o
   );
   modport slave (
      input  enable_i, money_i, drinktype_i, restock_i,
      output ready_o, enable_o, change_o, drink_o, vend_o, status_o
   );
`endif
endinterface

// File: rtl/autoseller_multi.sv
// Parametrised vending controller: IDLE/CALC/OUT purchase FSM with per-drink stock.
// Optional macro AUTOSELLER_REVENUE_EN adds a saturating 16-bit revenue counter.
module autoseller_multi #(
   parameter int MONEY_W    = 6,
   parameter int NUM_DRINKS = 4,
   parameter int TYPE_W     = 2,
   parameter int PRICE_BASE = 10,
   parameter int PRICE_STEP = 5,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 3
) (
   input  logic               clk,
   input  logic               reset,
   autoseller_multi_if.slave  bus
);
   localparam int PW = MONEY_W + TYPE_W;

   if (NUM_DRINKS < 2 || NUM_DRINKS > (1 << TYPE_W)) begin : g_bad_num_drinks
      $error("autoseller_multi: NUM_DRINKS out of range");
   end
   if (STOCK_INIT >= (1 << STOCK_W)) begin : g_bad_stock_init
      $error("autoseller_multi: STOCK_INIT does not fit STOCK_W");
   end

   typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

   state_t                       state_reg;
   logic [MONEY_W-1:0]           money_reg;
   logic [TYPE_W-1:0]            type_reg;
   logic                         ready_reg;
   logic                         enable_reg;
   logic [MONEY_W-1:0]           change_reg;
   logic [TYPE_W-1:0]            drink_reg;
   logic                         vend_reg;
   logic [1:0]                   status_reg;
   logic [NUM_DRINKS*STOCK_W-1:0] stock_flat;

   logic                         valid_type;
   logic                         stock_empty;
   logic [PW-1:0]                price_full;
   logic                         money_short;
   logic [1:0]                   dec_status;
   logic                         dec_vend;
   logic [MONEY_W-1:0]           dec_change;
   logic                         do_vend;

   // Select the latched drink's counter without indexing past NUM_DRINKS.
   always_comb begin
      valid_type  = 1'b0;
      stock_empty = 1'b1;
      for (int i = 0; i < NUM_DRINKS; i++) begin
         if (type_reg == TYPE_W'(i)) begin
            valid_type  = 1'b1;
            stock_empty = (stock_flat[i*STOCK_W +: STOCK_W] == '0);
         end
      end
   end

   assign price_full  = PW'(PRICE_BASE) + PW'(type_reg) * PW'(PRICE_STEP);
   assign money_short = (PW'(money_reg) < price_full);

   always_comb begin
      dec_status = 2'b00;
      dec_vend   = 1'b0;
      dec_change = money_reg;
      if (!valid_type) begin
         dec_status = 2'b11;
      end else if (stock_empty) begin
         dec_status = 2'b10;
      end else if (money_short) begin
         dec_status = 2'b01;
      end else begin
         dec_vend   = 1'b1;
         dec_change = money_reg - price_full[MONEY_W-1:0];
      end
   end

   assign do_vend = (state_reg == CALC) && dec_vend;

   genvar gi;
   for (gi = 0; gi < NUM_DRINKS; gi++) begin : g_stock
      logic [STOCK_W-1:0] cnt_reg;

      if (PRICE_BASE + gi * PRICE_STEP >= (1 << MONEY_W)) begin : g_bad_price
         $error("autoseller_multi: price does not fit MONEY_W");
      end

      // Restock has priority over a decrement on the same edge.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cnt_reg <= STOCK_W'(STOCK_INIT);
         end else if (bus.restock_i) begin
            cnt_reg <= STOCK_W'(STOCK_INIT);
         end else if (do_vend && (type_reg == TYPE_W'(gi))) begin
            cnt_reg <= cnt_reg - 1'b1;
         end
      end

      assign stock_flat[gi*STOCK_W +: STOCK_W] = cnt_reg;
   end

`ifdef AUTOSELLER_REVENUE_EN
   logic [15:0]        revenue_reg;
   logic [MONEY_W-1:0] price_reg;
   logic [16:0]        revenue_sum;

   assign revenue_sum   = {1'b0, revenue_reg} + 17'(price_reg);
   assign bus.revenue_o = revenue_reg;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         money_reg   <= '0;
         type_reg    <= '0;
         ready_reg   <= 1'b1;
         enable_reg  <= 1'b0;
         change_reg  <= '0;
         drink_reg   <= '0;
         vend_reg    <= 1'b0;
         status_reg  <= 2'b00;
`ifdef AUTOSELLER_REVENUE_EN
         revenue_reg <= '0;
         price_reg   <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.enable_i) begin
                  money_reg <= bus.money_i;
                  type_reg  <= bus.drinktype_i;
                  ready_reg <= 1'b0;
                  state_reg <= CALC;
               end
            end
            CALC: begin
               enable_reg <= 1'b1;
               change_reg <= dec_change;
               drink_reg  <= type_reg;
               vend_reg   <= dec_vend;
               status_reg <= dec_status;
`ifdef AUTOSELLER_REVENUE_EN
               price_reg  <= price_full[MONEY_W-1:0];
`endif
               state_reg  <= OUT;
            end
            OUT: begin
`ifdef AUTOSELLER_REVENUE_EN
               if (vend_reg) begin
                  revenue_reg <= revenue_sum[16] ? 16'hFFFF : revenue_sum[15:0];
               end
`endif
               enable_reg <= 1'b0;
               change_reg <= '0;
               drink_reg  <= '0;
               vend_reg   <= 1'b0;
               status_reg <= 2'b00;
               ready_reg  <= 1'b1;
               state_reg  <= IDLE;
            end
            default: begin
               ready_reg <= 1'b1;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready_o  = ready_reg;
   assign bus.enable_o = enable_reg;
   assign bus.change_o = change_reg;
   assign bus.drink_o  = drink_reg;
   assign bus.vend_o   = vend_reg;
   assign bus.status_o = status_reg;
endmodule
